// File: rtl/sd_resp_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_resp_rx_if
// Description : Bundle between the SD response receiver, the card data pin
//               and the sequencers that arm it and consume its results.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_resp_rx_if;
  logic        SD_IN;
  logic        rx_start;
  logic [1:0]  rx_type;
  logic        busy;
  logic [39:0] resp;
  logic        resp_valid;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [15:0] crc_out;
  logic        block_done;
  logic        timeout;

  // Sequencer / card side
  modport master (
    output SD_IN, rx_start, rx_type,
    input  busy, resp, resp_valid, data_out, data_valid, crc_out, block_done, timeout
  );

  // Receiver side
  modport slave (
    input  SD_IN, rx_start, rx_type,
    output busy, resp, resp_valid, data_out, data_valid, crc_out, block_done, timeout
  );
endinterface
`default_nettype wire

// File: rtl/sd_resp_rx.sv
`default_nettype none
// ============================================================================
// Module      : sd_resp_rx
// Description : SPI-mode SD receiver. Captures R1/R7 responses from the MISO
//               stream and, for single-block reads, the 0xFE token, the data
//               bytes and the trailing CRC16.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_resp_rx #(
  parameter int TIMEOUT       = 255,
  parameter int TOKEN_TIMEOUT = 4095,
  parameter int BLOCK_LEN     = 512
) (
  input wire          SD_CLK,
  input wire          rst_n,
  sd_resp_rx_if.slave bus
);

  // One down-counter serves both the start-bit and the token wait.
  localparam int CNT_MAX = (TOKEN_TIMEOUT > TIMEOUT) ? TOKEN_TIMEOUT : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BYTE_W  = $clog2(BLOCK_LEN) + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  START_LD   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  TOKEN_LD   = CNT_W'(TOKEN_TIMEOUT);
  localparam logic [BYTE_W-1:0] BYTE_ONE   = BYTE_W'(1);
  localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(BLOCK_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_SHIFT_RESP = 3'd2,
    S_WAIT_TOKEN = 3'd3,
    S_DATA       = 3'd4,
    S_CRC        = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         type_q, type_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         bit_q, bit_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic [38:0]        shift_q, shift_d;
  logic [7:0]         win_q, win_d;
  logic               busy_q, busy_d;
  logic [39:0]        resp_q, resp_d;
  logic               resp_valid_q, resp_valid_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic [15:0]        crc_q, crc_d;
  logic               block_done_q, block_done_d;
  logic               timeout_q, timeout_d;

  // Shift register and token window with the current bit appended.
  logic [39:0] w_shift;
  logic [7:0]  w_win;
  assign w_shift = {shift_q, bus.SD_IN};
  assign w_win   = {win_q[6:0], bus.SD_IN};

  // Next-state and output computation; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    shift_d      = shift_q;
    win_d        = win_q;
    resp_d       = resp_q;
    data_out_d   = data_out_q;
    crc_d        = crc_q;
    resp_valid_d = 1'b0;
    data_valid_d = 1'b0;
    block_done_d = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_start) begin
          state_d = S_WAIT_START;
          type_d  = (bus.rx_type == 2'd3) ? 2'd0 : bus.rx_type;
          cnt_d   = START_LD;
        end
      end

      S_WAIT_START: begin
        // A zero wins over counter expiry in the same cycle.
        if (!bus.SD_IN) begin
          shift_d = w_shift[38:0];
          bit_d   = 6'd1;
          state_d = S_SHIFT_RESP;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_SHIFT_RESP: begin
        shift_d = w_shift[38:0];
        bit_d   = bit_q + 6'd1;
        if ((type_q == 2'd1) ? (bit_q == 6'd39) : (bit_q == 6'd7)) begin
          resp_valid_d = 1'b1;
          resp_d       = (type_q == 2'd1) ? w_shift : {32'h0, w_shift[7:0]};
          if ((type_q == 2'd2) && (w_shift[7:0] == 8'h00)) begin
            state_d = S_WAIT_TOKEN;
            cnt_d   = TOKEN_LD;
            // Cleared so only eight freshly received bits can form the token.
            win_d   = 8'h00;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_WAIT_TOKEN: begin
        win_d = w_win;
        if (w_win == 8'hFE) begin
          state_d = S_DATA;
          bit_d   = 6'd0;
          byte_d  = '0;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DATA: begin
        shift_d = w_shift[38:0];
        bit_d   = bit_q + 6'd1;
        if (bit_q == 6'd7) begin
          bit_d        = 6'd0;
          data_out_d   = w_shift[7:0];
          data_valid_d = 1'b1;
          byte_d       = byte_q + BYTE_ONE;
          if (byte_q == BYTE_LAST) begin
            state_d = S_CRC;
          end
        end
      end

      S_CRC: begin
        crc_d = {crc_q[14:0], bus.SD_IN};
        bit_d = bit_q + 6'd1;
        if (bit_q == 6'd15) begin
          block_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge SD_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      type_q       <= 2'd0;
      cnt_q        <= '0;
      bit_q        <= 6'd0;
      byte_q       <= '0;
      shift_q      <= '0;
      win_q        <= 8'h00;
      busy_q       <= 1'b0;
      resp_q       <= 40'h0;
      resp_valid_q <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      crc_q        <= 16'h0;
      block_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      shift_q      <= shift_d;
      win_q        <= win_d;
      busy_q       <= busy_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      crc_q        <= crc_d;
      block_done_q <= block_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.resp       = resp_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.crc_out    = crc_q;
  assign bus.block_done = block_done_q;
  assign bus.timeout    = timeout_q;

endmodule
`default_nettype wire

// File: doc/sd_resp_rx.md
# sd_resp_rx

SPI-mode SD response and read-data receiver. It consumes the serial MISO stream driven by the SD card and captures R1 and R7 command responses. For single-block reads it also captures the 0xFE start token, the data block and the CRC16. It sits in the DUT between the card pin and the initialisation and read sequencers: they arm it after sending a command, then wait for its result pulse.

## Interface
Parameters:
- TIMEOUT, 255: maximum bit-clocks spent waiting for a response start bit.
- TOKEN_TIMEOUT, 4095: maximum bit-clocks spent waiting for the 0xFE token.
- BLOCK_LEN, 512: data bytes per block.

Ports:
- SD_CLK  in  1  bit clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- SD_IN  in  1  serial data from card, MSB first; idles high.
- rx_start  in  1  one-cycle pulse that arms the receiver; sampled only in IDLE.
- rx_type  in  2  sampled with rx_start: 0 = R1 (8 bit), 1 = R7 (40 bit), 2 = R1 + data block, 3 = reserved (treated as 0).
- busy  out  1  high from the cycle after an accepted rx_start until return to IDLE.
- resp  out  40  last response, right-aligned; R1 occupies [7:0] with upper bits 0.
- resp_valid  out  1  one-cycle pulse when resp is updated.
- data_out  out  8  current data byte.
- data_valid  out  1  one-cycle pulse per data byte.
- crc_out  out  16  received CRC16 of the block (not checked).
- block_done  out  1  one-cycle pulse after the last CRC bit.
- timeout  out  1  one-cycle pulse when a start bit or token wait expires.

## Operation
- States:
  - IDLE
  - WAIT_START
  - SHIFT_RESP
  - WAIT_TOKEN
  - DATA
  - CRC
- IDLE:
  - rx_start=1 → WAIT_START.
  - Latch rx_type.
  - Load the wait counter with TIMEOUT.
  - busy rises on the next cycle.
- WAIT_START, per bit-clock:
  - SD_IN=0 → it is bit 7 of the response. Shift it in, set bit count = 1, go to SHIFT_RESP.
  - SD_IN=1 → decrement the counter. If the counter is 0 → pulse timeout, go to IDLE, leave resp unchanged.
- SHIFT_RESP:
  - Shift SD_IN into a 40-bit register, MSB first.
  - Complete at 8 bits (types 0 and 2) or 40 bits (type 1).
  - On completion, load resp and pulse resp_valid.
  - Types 0 and 1 → IDLE.
  - Type 2 with R1 == 8'h00 → WAIT_TOKEN, counter = TOKEN_TIMEOUT.
  - Type 2 with R1 != 8'h00 → IDLE, no data phase.
- WAIT_TOKEN:
  - Shift SD_IN into an 8-bit window every bit-clock.
  - Window == 8'hFE → DATA, bit count = 0, byte count = 0.
  - Otherwise decrement the counter. If the counter is 0 → pulse timeout, go to IDLE.
- DATA:
  - Assemble bytes MSB first.
  - On the 8th bit, update data_out and pulse data_valid; increment the byte count (width clog2(BLOCK_LEN)+1).
  - After byte BLOCK_LEN-1 → CRC.
- CRC:
  - Shift 16 bits into crc_out, MSB first.
  - After the 16th bit → pulse block_done, go to IDLE.
- rx_start while busy is ignored and does not restart the receiver.
- Only one of resp_valid, data_valid, block_done and timeout pulses in any cycle.
- Counters saturate at 0 and never wrap.

## Timing
- Reset values:
  - busy, resp_valid, data_valid, block_done, timeout = 0.
  - resp = 40'h0, data_out = 8'h0, crc_out = 16'h0.
  - state = IDLE.
- Reset mid-operation: all state and outputs return to the reset values immediately (asynchronous). No pulse is emitted for the aborted transfer.
- A start bit sampled at edge k:
  - R1: resp_valid is high in the cycle after edge k+7.
  - R7: resp_valid is high in the cycle after edge k+39.
- Token completion at edge t:
  - Bits of byte 0 are sampled at edges t+1 through t+8.
  - data_valid for byte 0 is high after edge t+8; byte n follows 8 clocks later per byte.
- block_done is high after edge t + 8·BLOCK_LEN + 16.
- A start bit is accepted on the first WAIT_START edge, i.e. the edge after rx_start.
- Timeout pulse:
  - WAIT_START: exactly TIMEOUT+1 edges of SD_IN=1 after arming.
  - WAIT_TOKEN: exactly TOKEN_TIMEOUT+1 edges without a token match.
- A 0 bit in the same cycle as counter expiry counts as a start bit; the timeout is suppressed.

## Test plan
- R1 response: rx_start with type 0, SD_IN=1 for 3 clocks, then 8'h01 → resp=40'h01, one resp_valid pulse, busy low on the next cycle.
- R7 response: type 1, card sends 40'h01_000001AA after 5 idle clocks → resp=40'h01000001AA, no data_valid.
- Start-bit timeout: type 0, SD_IN held 1 → timeout pulses after 256 edges, resp keeps its previous value. A repeat run with the start bit on edge 256 gives resp_valid and no timeout.
- Block read: type 2, card sends R1 8'h00, 16 one bits, 8'hFE, 512 bytes (i mod 256), CRC 16'h1234.
  - Expect 512 data_valid pulses with values 0..255, 0..255.
  - Expect crc_out=16'h1234 and one block_done pulse.
- R1 error in data mode: type 2, R1=8'h04 → resp=40'h04, no WAIT_TOKEN entry, idle again one cycle later. A following 0xFE is ignored.
- Reset and busy protection:
  - rst_n low after byte 100 of a block → all outputs 0 and IDLE; a new type 0 read then works.
  - rx_start pulsed during DATA is ignored, and the byte count is unaffected.
